// File: rtl/issue_ctrl.sv
// issue_ctrl: decode-stage issue/stall decision from a long-latency register scoreboard,
// divider occupancy and a post-control-transfer bubble counter.
module issue_ctrl #(
   parameter int CTRL_BUBBLES = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  id_rd,
   input  logic        id_reg_we,
   input  logic        id_long,
   input  logic        id_div,
   input  logic        id_ctrl,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic        div_ready,
   output logic        issue,
   output logic        stall,
   output logic [31:0] pending,
   output logic        div_busy,
   output logic        bubble,
   output logic [31:0] stall_count
);
   typedef enum logic {ISSUE, BUBBLE} state_t;
   localparam logic [2:0] NB = 3'(CTRL_BUBBLES);
   state_t      r_state;
   logic [2:0]  r_bcnt;
   logic [31:0] r_pending;
   logic        r_div_busy;
   logic [31:0] r_stall_count;
   logic        w_haz;
   logic        w_issue;
   logic        w_stall;
   logic [31:0] w_set;
   logic [31:0] w_clr;
   assign w_haz = (id_rs1_used & r_pending[id_rs1]) | (id_rs2_used & r_pending[id_rs2]) |
                  (id_reg_we & r_pending[id_rd]) | (id_div & r_div_busy);
   assign w_issue = reset_n & run & id_valid & (r_state == ISSUE) & ~w_haz;
   assign w_stall = id_valid & ~w_issue;
   // x0 is never marked; a set on the same bit as a clear wins because it is ORed in last
   assign w_set = (w_issue & id_reg_we & id_long & (id_rd != 5'd0)) ? 32'd1 << id_rd : 32'd0;
   assign w_clr = (wb_we & (wb_rd != 5'd0)) ? 32'd1 << wb_rd : 32'd0;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= ISSUE;
         r_bcnt        <= 3'd0;
         r_pending     <= 32'd0;
         r_div_busy    <= 1'b0;
         r_stall_count <= 32'd0;
      end else begin
         r_pending     <= (r_pending & ~w_clr) | w_set;
         r_div_busy    <= ~div_ready & (r_div_busy | (w_issue & id_div));
         r_stall_count <= r_stall_count + {31'd0, w_stall};
         if (r_state == ISSUE) begin
            if (w_issue & id_ctrl & (NB != 3'd0)) begin
               r_state <= BUBBLE;
               r_bcnt  <= NB;
            end
         end else if (run) begin
            r_bcnt <= r_bcnt - 3'd1;
            if (r_bcnt == 3'd1) r_state <= ISSUE;
         end
      end
   end
   assign issue       = w_issue;
   assign stall       = w_stall;
   assign pending     = r_pending;
   assign div_busy    = r_div_busy;
   assign bubble      = (r_state == BUBBLE);
   assign stall_count = r_stall_count;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: table vectors, scripted corner sequences and random traffic,
// all cross-checked every cycle against a counter/bit-array reference model.
module tb_issue_ctrl;
   localparam int NB = 3;
   logic clk = 1'b0;
   logic reset_n, run, id_valid, id_rs1_used, id_rs2_used, id_reg_we, id_long, id_div, id_ctrl;
   logic wb_we, div_ready;
   logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
   logic issue, stall, div_busy, bubble;
   logic [31:0] pending, stall_count;

   issue_ctrl #(.CTRL_BUBBLES(NB)) dut (
      .clk(clk), .reset_n(reset_n), .run(run), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_we(id_reg_we), .id_long(id_long), .id_div(id_div), .id_ctrl(id_ctrl),
      .wb_we(wb_we), .wb_rd(wb_rd), .div_ready(div_ready),
      .issue(issue), .stall(stall), .pending(pending), .div_busy(div_busy),
      .bubble(bubble), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst_n, run, valid, u1, u2, we, lng, dv, ctrl, wbwe, dr;
      logic [4:0] rs1, rs2, rd, wbrd;
   } in_t;

   typedef struct {
      in_t i;
      logic ei;
      logic [31:0] ep;
      logic eb;
      logic ebub;
   } vec_t;

   int n_tests = 0;
   int n_fail = 0;
   logic got;

   // reference model state: pending bits, divider flag, remaining bubble cycles, stall tally
   logic [31:0] m_pend = 0;
   logic m_busy = 0;
   int m_bub = 0;
   logic [31:0] m_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t mk(input logic rst_n, valid, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rd, input logic we, lng, dv, ctrl, wbwe,
                              input logic [4:0] wbrd, input logic dr);
      in_t v;
      v.rst_n = rst_n; v.run = 1'b1; v.valid = valid; v.rs1 = rs1; v.u1 = u1;
      v.rs2 = 5'd0; v.u2 = 1'b0; v.rd = rd; v.we = we; v.lng = lng; v.dv = dv;
      v.ctrl = ctrl; v.wbwe = wbwe; v.wbrd = wbrd; v.dr = dr;
      return v;
   endfunction

   function automatic logic model_issue(input in_t v);
      logic blocked;
      blocked = (v.u1 && m_pend[v.rs1]) || (v.u2 && m_pend[v.rs2]) ||
                (v.we && m_pend[v.rd]) || (v.dv && m_busy) || (m_bub > 0);
      return v.rst_n && v.run && v.valid && !blocked;
   endfunction

   task automatic cyc(input in_t v);
      logic ei;
      reset_n = v.rst_n; run = v.run; id_valid = v.valid;
      id_rs1 = v.rs1; id_rs1_used = v.u1; id_rs2 = v.rs2; id_rs2_used = v.u2;
      id_rd = v.rd; id_reg_we = v.we; id_long = v.lng; id_div = v.dv; id_ctrl = v.ctrl;
      wb_we = v.wbwe; wb_rd = v.wbrd; div_ready = v.dr;
      ei = model_issue(v);
      #1;
      got = issue;
      chk("issue", {31'd0, issue}, {31'd0, ei});
      chk("stall", {31'd0, stall}, {31'd0, v.valid & ~ei});
      if (!v.rst_n) begin
         m_pend = 0; m_busy = 0; m_bub = 0; m_cnt = 0;
      end else begin
         if (v.valid && !ei) m_cnt = m_cnt + 1;
         if (v.wbwe && v.wbrd != 0) m_pend[v.wbrd] = 1'b0;
         if (ei && v.we && v.lng && v.rd != 0) m_pend[v.rd] = 1'b1;
         if (v.dr) m_busy = 0;
         else if (ei && v.dv) m_busy = 1;
         if (m_bub > 0) begin
            if (v.run) m_bub--;
         end else if (ei && v.ctrl) m_bub = NB;
      end
      @(posedge clk);
      #1;
      chk("pending", pending, m_pend);
      chk("div_busy", {31'd0, div_busy}, {31'd0, m_busy});
      chk("bubble", {31'd0, bubble}, {31'd0, logic'(m_bub > 0)});
      chk("stall_count", stall_count, m_cnt);
   endtask

   vec_t tbl[16];
   in_t nop, v;
   logic [3:0] seen;
   int cnt;

   initial begin
      nop = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0]  = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 32'h0,  0, 0};
      tbl[1]  = '{mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h0,  0, 0};
      tbl[2]  = '{mk(1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0), 1, 32'h20, 0, 0};
      tbl[3]  = '{mk(1, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0), 0, 32'h20, 0, 0};
      tbl[4]  = '{mk(1, 1, 5, 1, 6, 1, 0, 0, 0, 1, 5, 0), 0, 32'h0,  0, 0};
      tbl[5]  = '{mk(1, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0), 1, 32'h0,  0, 0};
      tbl[6]  = '{mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1, 32'h0,  0, 0};
      tbl[7]  = '{mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h0,  0, 0};
      tbl[8]  = '{mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1, 32'h0,  1, 0};
      tbl[9]  = '{mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), 0, 32'h0,  0, 0};
      tbl[10] = '{mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1, 32'h0,  1, 0};
      tbl[11] = '{mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1, 32'h0,  1, 1};
      tbl[12] = '{mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 32'h0,  0, 1};
      tbl[13] = '{mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 32'h0,  0, 1};
      tbl[14] = '{mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 32'h0,  0, 0};
      tbl[15] = '{mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h0,  0, 0};
      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].i);
         chk($sformatf("tbl%0d_issue", i), {31'd0, got}, {31'd0, tbl[i].ei});
         chk($sformatf("tbl%0d_pend", i), pending, tbl[i].ep);
         chk($sformatf("tbl%0d_busy", i), {31'd0, div_busy}, {31'd0, tbl[i].eb});
         chk($sformatf("tbl%0d_bubble", i), {31'd0, bubble}, {31'd0, tbl[i].ebub});
      end

      // reset then 4 clean issues
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++) begin
         cyc(nop);
         chk("clean_issue", {31'd0, got}, 32'd1);
      end
      chk("clean_pend", pending, 32'd0);
      chk("clean_cnt", stall_count, 32'd0);

      // load-use: load x5 in cycle 1, reader cycles 2..5, writeback in cycle 4
      cyc(mk(1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0));
      seen = 0;
      for (int c = 2; c <= 5; c++) begin
         cyc(mk(1, 1, 5, 1, 9, 1, 0, 0, 0, c == 4, 5, 0));
         seen[c-2] = got;
         if (c == 3) chk("lu_pend_held", pending, 32'h20);
      end
      chk("lu_issue_pattern", {28'd0, seen}, 32'h8);
      chk("lu_stall_count", stall_count, 32'd3);
      chk("lu_pend_clear", pending, 32'd0);

      // branch, then run low for 2 cycles mid-bubble: 5 wall cycles of bubble
      cyc(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      cnt = 0;
      for (int c = 0; c < 12 && bubble; c++) begin
         v = nop;
         v.run = !(c == 1 || c == 2);
         cnt++;
         cyc(v);
      end
      chk("bubble_wall_cycles", cnt, 5);

      // div in cycle 1, second div from cycle 2, div_ready in cycle 6
      cyc(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      cnt = 0;
      for (int c = 2; c <= 7; c++) begin
         cyc(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, c == 6));
         if (got) chk("div2_issue_cycle", c, 7);
         if (c == 6) chk("div_busy_dropped", {31'd0, div_busy}, 32'd0);
      end
      chk("div_busy_again", {31'd0, div_busy}, 32'd1);
      cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

      // reset abandons pending x7 and busy divider
      cyc(mk(1, 1, 0, 0, 7, 1, 1, 1, 0, 0, 0, 0));
      cyc(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("rst_pend", pending, 32'd0);
      chk("rst_busy", {31'd0, div_busy}, 32'd0);
      cyc(mk(1, 1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0));
      chk("rst_reader_issue", {31'd0, got}, 32'd1);

      // random traffic on a small register window to provoke hazards
      for (int i = 0; i < 500; i++) begin
         v.rst_n = ($urandom_range(0, 49) != 0);
         v.run   = ($urandom_range(0, 9) != 0);
         v.valid = ($urandom_range(0, 4) != 0);
         v.rs1 = 5'($urandom_range(0, 3)); v.u1 = 1'($urandom);
         v.rs2 = 5'($urandom_range(0, 3)); v.u2 = 1'($urandom);
         v.rd  = 5'($urandom_range(0, 3)); v.we = 1'($urandom);
         v.lng = ($urandom_range(0, 2) == 0);
         v.dv  = ($urandom_range(0, 5) == 0);
         v.ctrl = ($urandom_range(0, 9) == 0);
         v.wbwe = ($urandom_range(0, 2) == 0);
         v.wbrd = 5'($urandom_range(0, 3));
         v.dr   = ($urandom_range(0, 4) == 0);
         cyc(v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
